count_sequencer: RTL and testbench



---
 rtl/count_sequencer_pkg.sv | 8 +
 rtl/count_step_unit.sv | 52 +++++
 rtl/count_sequencer.sv | 77 +++++++
 tb/tb_count_sequencer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/count_sequencer_pkg.sv
// count_sequencer_pkg: mode and state encodings shared by the count sequencer files
package count_sequencer_pkg;
    localparam logic [1:0] MODE_ONESHOT_UP   = 2'b00;
    localparam logic [1:0] MODE_ONESHOT_DOWN = 2'b01;
    localparam logic [1:0] MODE_WRAP_UP      = 2'b10;
    localparam logic [1:0] MODE_PINGPONG     = 2'b11;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD, ST_DONE} state_t;
endpackage

// File: rtl/count_step_unit.sv
// count_step_unit: next count/dir, turnaround and end-of-run decode for one step
module count_step_unit
    import count_sequencer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] nxt_count,
    output logic             nxt_dir,
    output logic             wrap,
    output logic             at_end
);
    logic at_hi, at_lo, flat;
    always_comb begin
        at_hi = count == hi;
        at_lo = count == lo;
        flat = lo == hi;
        nxt_count = count;
        nxt_dir = dir;
        wrap = 1'b0;
        at_end = 1'b0;
        case (mode)
            MODE_ONESHOT_UP: begin
                at_end = at_hi;
                nxt_count = at_hi ? count : count + WIDTH'(1);
            end
            MODE_ONESHOT_DOWN: begin
                at_end = at_lo;
                nxt_count = at_lo ? count : count - WIDTH'(1);
            end
            MODE_WRAP_UP: begin
                wrap = at_hi;
                nxt_count = at_hi ? lo : count + WIDTH'(1);
            end
            default: begin
                // a one-value window turns around in place without flipping dir
                wrap = dir ? at_hi : at_lo;
                if (dir) begin
                    nxt_count = !at_hi ? count + WIDTH'(1) : flat ? count : hi - WIDTH'(1);
                    nxt_dir = !(at_hi && !flat);
                end else begin
                    nxt_count = !at_lo ? count - WIDTH'(1) : flat ? count : lo + WIDTH'(1);
                    nxt_dir = at_lo && !flat;
                end
            end
        endcase
    end
endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: run-control FSM stepping a windowed up/down count once per clock
module count_sequencer
    import count_sequencer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] Count,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic             cfg_err
);
    state_t state;
    logic [1:0] mode_q;
    logic [WIDTH-1:0] lo_q, hi_q, nxt_count;
    logic nxt_dir, step_wrap, at_end;

    count_step_unit #(.WIDTH(WIDTH)) u_step (
        .count(Count), .dir(dir), .mode(mode_q), .lo(lo_q), .hi(hi_q),
        .nxt_count(nxt_count), .nxt_dir(nxt_dir), .wrap(step_wrap), .at_end(at_end)
    );

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            mode_q <= '0;
            lo_q <= '0;
            hi_q <= '0;
            Count <= '0;
            dir <= 1'b1;
            busy <= 1'b0;
            done <= 1'b0;
            wrap <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            done <= 1'b0;
            wrap <= 1'b0;
            cfg_err <= 1'b0;
            if (stop) begin
                state <= ST_IDLE;
                busy <= 1'b0;
            end else if (state == ST_IDLE || state == ST_DONE) begin
                if (start && !pause) begin
                    if (lo > hi) begin
                        cfg_err <= 1'b1;
                    end else begin
                        state <= ST_RUN;
                        busy <= 1'b1;
                        mode_q <= mode;
                        lo_q <= lo;
                        hi_q <= hi;
                        Count <= mode == MODE_ONESHOT_DOWN ? hi : lo;
                        dir <= mode != MODE_ONESHOT_DOWN;
                    end
                end
            end else if (pause) begin
                state <= ST_HOLD;
            end else begin
                Count <= nxt_count;
                dir <= nxt_dir;
                wrap <= step_wrap;
                state <= at_end ? ST_DONE : ST_RUN;
                busy <= !at_end;
                done <= at_end;
            end
        end
    end
endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: table-driven scoreboard bench for count_sequencer
module tb_count_sequencer;
    logic Clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, pause = 1'b0;
    logic [1:0] mode = '0;
    logic [3:0] lo = '0, hi = '0, Count;
    logic dir, busy, done, wrap, cfg_err;
    int n_checks = 0, n_fail = 0;

    typedef struct {
        string name;
        logic st, sp, pa;
        logic [1:0] m;
        logic [3:0] l, h;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];
    logic [8:0] sb[$];
    string sb_name[$];

    count_sequencer #(.WIDTH(4)) dut (
        .Clk(Clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .mode(mode), .lo(lo), .hi(hi), .Count(Count), .dir(dir), .busy(busy),
        .done(done), .wrap(wrap), .cfg_err(cfg_err)
    );

    always #5 Clk = ~Clk;

    function automatic void add(string n, int st, int sp, int pa, int m, int l, int h,
                                int c, int d, int b, int dn, int w, int ce);
        vec_t v;
        v.name = n;
        v.st = 1'(st);
        v.sp = 1'(sp);
        v.pa = 1'(pa);
        v.m = 2'(m);
        v.l = 4'(l);
        v.h = 4'(h);
        v.exp = {4'(c), 1'(d), 1'(b), 1'(dn), 1'(w), 1'(ce)};
        vecs.push_back(v);
    endfunction

    task automatic expect_now(string n, logic [8:0] e);
        sb.push_back(e);
        sb_name.push_back(n);
    endtask

    task automatic compare_one();
        logic [8:0] act, e;
        string n;
        act = {Count, dir, busy, done, wrap, cfg_err};
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: no expected entry for output %b", act);
        end else begin
            e = sb.pop_front();
            n = sb_name.pop_front();
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got Count=%0d dir,busy,done,wrap,cfg_err=%b, required Count=%0d dir,busy,done,wrap,cfg_err=%b",
                         n, act[8:5], act[4:0], e[8:5], e[4:0]);
            end
        end
    endtask

    task automatic apply(vec_t v);
        start = v.st;
        stop = v.sp;
        pause = v.pa;
        mode = v.m;
        lo = v.l;
        hi = v.h;
        expect_now(v.name, v.exp);
        @(posedge Clk);
        #1;
        compare_one();
    endtask

    initial begin
        // oneshot up 2..5 with an ignored mid-run start carrying new config
        add("a_start",        1,0,0, 0,2,5,   2,1,1,0,0,0);
        add("a_start_in_run", 1,0,0, 3,0,15,  3,1,1,0,0,0);
        add("a_step4",        0,0,0, 0,0,0,   4,1,1,0,0,0);
        add("a_step5",        0,0,0, 0,0,0,   5,1,1,0,0,0);
        add("a_done",         0,0,0, 0,0,0,   5,1,0,1,0,0);
        add("a_done_once",    0,0,0, 0,0,0,   5,1,0,0,0,0);
        // pingpong 0..3 restarted from DONE
        add("b_start",        1,0,0, 3,0,3,   0,1,1,0,0,0);
        add("b_1",            0,0,0, 0,0,0,   1,1,1,0,0,0);
        add("b_2",            0,0,0, 0,0,0,   2,1,1,0,0,0);
        add("b_3",            0,0,0, 0,0,0,   3,1,1,0,0,0);
        add("b_turn_hi",      0,0,0, 0,0,0,   2,0,1,0,1,0);
        add("b_1_down",       0,0,0, 0,0,0,   1,0,1,0,0,0);
        add("b_0_down",       0,0,0, 0,0,0,   0,0,1,0,0,0);
        add("b_turn_lo",      0,0,0, 0,0,0,   1,1,1,0,1,0);
        add("b_2_up",         0,0,0, 0,0,0,   2,1,1,0,0,0);
        add("b_stop",         0,1,0, 0,0,0,   2,1,0,0,0,0);
        // wrap-up 12..15 with pause and stop
        add("c_start",        1,0,0, 2,12,15, 12,1,1,0,0,0);
        add("c_13",           0,0,0, 0,0,0,   13,1,1,0,0,0);
        add("c_14",           0,0,0, 0,0,0,   14,1,1,0,0,0);
        add("c_15",           0,0,0, 0,0,0,   15,1,1,0,0,0);
        add("c_wrap",         0,0,0, 0,0,0,   12,1,1,0,1,0);
        add("c_13b",          0,0,0, 0,0,0,   13,1,1,0,0,0);
        add("c_pause1",       0,0,1, 0,0,0,   13,1,1,0,0,0);
        add("c_pause2",       0,0,1, 0,0,0,   13,1,1,0,0,0);
        add("c_pause3",       0,0,1, 0,0,0,   13,1,1,0,0,0);
        add("c_release",      0,0,0, 0,0,0,   14,1,1,0,0,0);
        add("c_15b",          0,0,0, 0,0,0,   15,1,1,0,0,0);
        add("c_stop",         0,1,0, 0,0,0,   15,1,0,0,0,0);
        // rejected configuration and start+stop collision
        add("d_cfg_err",      1,0,0, 0,7,4,   15,1,0,0,0,1);
        add("d_cfg_err_once", 0,0,0, 0,0,0,   15,1,0,0,0,0);
        add("d_start_stop",   1,1,0, 0,0,3,   15,1,0,0,0,0);
        add("d_still_idle",   0,0,0, 0,0,0,   15,1,0,0,0,0);
        // degenerate windows
        add("e_start",        1,0,0, 1,6,6,   6,0,1,0,0,0);
        add("e_done",         0,0,0, 0,0,0,   6,0,0,1,0,0);
        add("e_after",        0,0,0, 0,0,0,   6,0,0,0,0,0);
        add("f_start",        1,0,0, 3,6,6,   6,1,1,0,0,0);
        add("f_wrap1",        0,0,0, 0,0,0,   6,1,1,0,1,0);
        add("f_wrap2",        0,0,0, 0,0,0,   6,1,1,0,1,0);
        add("f_stop",         0,1,0, 0,0,0,   6,1,0,0,0,0);

        #12;
        expect_now("reset_state", {4'd0, 5'b10000});
        compare_one();
        reset = 1'b0;
        foreach (vecs[i]) apply(vecs[i]);

        // asynchronous reset in the middle of a wrap-up run
        apply('{"g_start", 1'b1, 1'b0, 1'b0, 2'd2, 4'd3, 4'd9, {4'd3, 5'b11000}});
        apply('{"g_step", 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, {4'd4, 5'b11000}});
        #3;
        reset = 1'b1;
        #1;
        expect_now("g_async_reset", {4'd0, 5'b10000});
        compare_one();
        reset = 1'b0;
        apply('{"g_idle_after", 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, {4'd0, 5'b10000}});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
